// File: rtl/instr_fetch_decode_pkg.sv
// Shared definitions for the program memory, fetch/decode and execute blocks:
// opcode constants, instruction field positions and the fetch FSM encoding.
package instr_fetch_decode_pkg;

    localparam int OPC_MSB = 14;
    localparam int OPC_LSB = 11;
    localparam int REG_MSB = 10;
    localparam int REG_LSB = 8;
    localparam int MEM_MSB = 7;
    localparam int MEM_LSB = 3;
    localparam int IMM_MSB = 2;
    localparam int IMM_LSB = 0;

    localparam logic [3:0] OP_LOAD_DIR = 4'b1110;
    localparam logic [3:0] OP_LOAD_MEM = 4'b1100;
    localparam logic [3:0] OP_STR      = 4'b1101;
    localparam logic [3:0] OP_MOV      = 4'b1011;
    localparam logic [3:0] OP_JMP      = 4'b0000;
    localparam logic [3:0] OP_HALT     = 4'b1111;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_WAIT   = 3'd1,
        ST_DECODE = 3'd2,
        ST_ISSUE  = 3'd3,
        ST_HALT   = 3'd4
    } fsm_state_t;

    typedef struct packed {
        logic ld_dir;
        logic ld_mem;
        logic str;
        logic mov;
        logic jmp;
        logic alu;
    } instr_class_t;

endpackage

// File: rtl/instr_fetch_decode_opcode_decoder.sv
// Combinational opcode-to-class decoder; HALT raises no class flag and every
// unlisted opcode is an ALU operation.
module opcode_decoder
    import instr_fetch_decode_pkg::*;
(
    input  logic [3:0]   i_opcode,
    output instr_class_t o_class
);

    always_comb begin
        o_class = '0;
        case (i_opcode)
            OP_LOAD_DIR: o_class.ld_dir = 1'b1;
            OP_LOAD_MEM: o_class.ld_mem = 1'b1;
            OP_STR:      o_class.str    = 1'b1;
            OP_MOV:      o_class.mov    = 1'b1;
            OP_JMP:      o_class.jmp    = 1'b1;
            OP_HALT:     o_class        = '0;
            default:     o_class.alu    = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_fetch_decode.sv
// Instruction fetch/decode engine: FETCH -> WAIT -> DECODE -> ISSUE, holding
// decoded fields stable for the execute stage until exec_done.
module instr_fetch_decode
    import instr_fetch_decode_pkg::*;
#(
    parameter int PC_W = 5,
    parameter int IW   = 15
) (
    input  logic            clk,
    input  logic            rst,
    output logic [PC_W-1:0] adp_bus,
    output logic            rd,
    output logic            wr,
    input  logic [IW-1:0]   pgm_line,
    output logic [3:0]      opcode,
    output logic [2:0]      add_reg,
    output logic [4:0]      add_mem,
    output logic [2:0]      data,
    output logic            is_ld_dir,
    output logic            is_ld_mem,
    output logic            is_str,
    output logic            is_mov,
    output logic            is_jmp,
    output logic            is_alu,
    output logic            instr_valid,
    input  logic            exec_done,
    output logic            halted,
    output logic [2:0]      dbg_state
);

    fsm_state_t   r_state;
    fsm_state_t   w_next;
    logic [PC_W-1:0] r_pc;
    logic [IW-1:0]   r_ir;
    logic [3:0]      r_opcode;
    logic [2:0]      r_add_reg;
    logic [4:0]      r_add_mem;
    logic [2:0]      r_data;
    instr_class_t    r_class;
    instr_class_t    w_class;

    opcode_decoder u_opcode_decoder (
        .i_opcode (r_ir[OPC_MSB:OPC_LSB]),
        .o_class  (w_class)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_FETCH:  w_next = ST_WAIT;
            ST_WAIT:   w_next = ST_DECODE;
            ST_DECODE: w_next = (r_ir[OPC_MSB:OPC_LSB] == OP_HALT) ? ST_HALT : ST_ISSUE;
            ST_ISSUE:  w_next = exec_done ? ST_FETCH : ST_ISSUE;
            ST_HALT:   w_next = ST_HALT;
            default:   w_next = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_FETCH;
            r_pc      <= '0;
            r_ir      <= '0;
            r_opcode  <= '0;
            r_add_reg <= '0;
            r_add_mem <= '0;
            r_data    <= '0;
            r_class   <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_WAIT: r_ir <= pgm_line;
                ST_DECODE: begin
                    r_opcode  <= r_ir[OPC_MSB:OPC_LSB];
                    r_add_reg <= r_ir[REG_MSB:REG_LSB];
                    r_add_mem <= r_ir[MEM_MSB:MEM_LSB];
                    r_data    <= r_ir[IMM_MSB:IMM_LSB];
                    r_class   <= w_class;
                end
                // The PC only moves once the execute stage has taken the instruction.
                ST_ISSUE: begin
                    if (exec_done) begin
                        r_pc <= r_class.jmp ? PC_W'(r_add_mem) : r_pc + PC_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // rd is gated by rst so the strobe is low for the whole reset window even
    // though the reset state is FETCH.
    assign rd          = (r_state == ST_FETCH) && !rst;
    assign wr          = 1'b0;
    assign adp_bus     = r_pc;
    assign instr_valid = (r_state == ST_ISSUE);
    assign halted      = (r_state == ST_HALT);
    assign dbg_state   = r_state;

    assign opcode    = r_opcode;
    assign add_reg   = r_add_reg;
    assign add_mem   = r_add_mem;
    assign data      = r_data;
    assign is_ld_dir = r_class.ld_dir;
    assign is_ld_mem = r_class.ld_mem;
    assign is_str    = r_class.str;
    assign is_mov    = r_class.mov;
    assign is_jmp    = r_class.jmp;
    assign is_alu    = r_class.alu;

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Bench for instr_fetch_decode: a 32-word program memory with one-cycle read
// latency and an instruction-level model of the fetch engine.
module tb_instr_fetch_decode;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  adp_bus;
    logic        rd;
    logic        wr;
    logic [14:0] pgm_line = '0;
    logic [3:0]  opcode;
    logic [2:0]  add_reg;
    logic [4:0]  add_mem;
    logic [2:0]  data;
    logic        is_ld_dir, is_ld_mem, is_str, is_mov, is_jmp, is_alu;
    logic        instr_valid;
    logic        exec_done = 1'b0;
    logic        halted;
    logic [2:0]  dbg_state;

    logic [14:0] mem [32];
    logic [4:0]  model_pc;
    int          checks = 0;
    int          errors = 0;

    instr_fetch_decode #(.PC_W(5), .IW(15)) dut (
        .clk         (clk),
        .rst         (rst),
        .adp_bus     (adp_bus),
        .rd          (rd),
        .wr          (wr),
        .pgm_line    (pgm_line),
        .opcode      (opcode),
        .add_reg     (add_reg),
        .add_mem     (add_mem),
        .data        (data),
        .is_ld_dir   (is_ld_dir),
        .is_ld_mem   (is_ld_mem),
        .is_str      (is_str),
        .is_mov      (is_mov),
        .is_jmp      (is_jmp),
        .is_alu      (is_alu),
        .instr_valid (instr_valid),
        .exec_done   (exec_done),
        .halted      (halted),
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    // Program memory: word appears one clock after the address is presented.
    always @(posedge clk) begin
        if (rd) pgm_line <= mem[adp_bus];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Class flags {ld_dir, ld_mem, str, mov, jmp, alu} from the opcode table.
    function automatic logic [5:0] exp_class(input logic [3:0] op);
        case (op)
            4'b1110: return 6'b100000;
            4'b1100: return 6'b010000;
            4'b1101: return 6'b001000;
            4'b1011: return 6'b000100;
            4'b0000: return 6'b000010;
            4'b1111: return 6'b000000;
            default: return 6'b000001;
        endcase
    endfunction

    function automatic logic [14:0] gen_word(input bit allow_jmp);
        logic [3:0] op;
        do op = 4'($urandom_range(0, 15));
        while (op == 4'b1111 || (!allow_jmp && op == 4'b0000));
        return {op, 11'($urandom_range(0, 2047))};
    endfunction

    task automatic chk_fields(input string tag, input logic [14:0] w);
        chk({tag, "_opcode"}, opcode, w[14:11]);
        chk({tag, "_add_reg"}, add_reg, w[10:8]);
        chk({tag, "_add_mem"}, add_mem, w[7:3]);
        chk({tag, "_data"}, data, w[2:0]);
        chk({tag, "_class"}, {is_ld_dir, is_ld_mem, is_str, is_mov, is_jmp, is_alu},
            exp_class(w[14:11]));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        exec_done = 1'($urandom_range(0, 1));
        #1;
        chk("rst_rd", rd, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_halted", halted, 0);
        chk("rst_pc", adp_bus, 0);
        chk("rst_fields", {opcode, add_reg, add_mem, data}, 0);
        chk("rst_class", {is_ld_dir, is_ld_mem, is_str, is_mov, is_jmp, is_alu}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exec_done = 1'b0;
        model_pc = '0;
        #1;
    endtask

    // Runs one instruction from its FETCH cycle to the next FETCH cycle.
    task automatic do_instr(input int delay, input bit abort);
        logic [14:0] w;
        chk("fetch_rd", rd, 1);
        chk("fetch_addr", adp_bus, model_pc);
        chk("fetch_valid", instr_valid, 0);
        chk("wr_low", wr, 0);
        w = mem[model_pc];
        exec_done = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("wait_rd", rd, 0);
        chk("wait_valid", instr_valid, 0);
        exec_done = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("decode_valid", instr_valid, 0);
        exec_done = 1'($urandom_range(0, 1));
        @(negedge clk);
        if (w[14:11] == 4'b1111) begin
            for (int i = 0; i < 20; i++) begin
                chk("halt_halted", halted, 1);
                chk("halt_rd", rd, 0);
                chk("halt_valid", instr_valid, 0);
                chk("halt_pc", adp_bus, model_pc);
                exec_done = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
            return;
        end
        chk("issue_valid", instr_valid, 1);
        chk("issue_halted", halted, 0);
        chk("issue_rd", rd, 0);
        chk_fields("issue", w);
        if (abort) begin
            exec_done = 1'b1;
            #2 rst = 1'b1;
            #1;
            chk("abort_valid", instr_valid, 0);
            chk("abort_pc", adp_bus, 0);
            @(negedge clk);
            rst = 1'b0;
            exec_done = 1'b0;
            model_pc = '0;
            #1;
            return;
        end
        exec_done = (delay == 0);
        for (int d = 1; d <= delay; d++) begin
            @(negedge clk);
            chk("hold_valid", instr_valid, 1);
            chk("hold_pc", adp_bus, model_pc);
            chk_fields("hold", w);
            if (d == delay) exec_done = 1'b1;
        end
        @(negedge clk);
        model_pc = (w[14:11] == 4'b0000) ? w[7:3] : model_pc + 5'd1;
        exec_done = 1'($urandom_range(0, 1));
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = '0;

        // Load-direct, delayed-ack load-direct, then HALT at address 2.
        mem[0] = 15'b111000000000001;
        mem[1] = 15'b111010100000101;
        mem[2] = 15'b111100000000000;
        do_reset();
        do_instr(0, 0);
        do_instr(5, 0);
        chk("pc_after_delayed_ack", adp_bus, 2);
        do_instr(0, 0);

        // Jump chain ending on a non-jump at 31, which must wrap to 0.
        mem[0]  = {4'b0000, 3'd0, 5'd3, 3'd0};
        mem[3]  = 15'b000000100100000;
        mem[4]  = {4'b0000, 3'd2, 5'd31, 3'd5};
        mem[31] = gen_word(0);
        do_reset();
        for (int i = 0; i < 5; i++) do_instr($urandom_range(0, 2), 0);

        // Jump to its own address.
        mem[0] = {4'b0000, 3'd1, 5'd0, 3'd0};
        do_reset();
        for (int i = 0; i < 3; i++) do_instr(0, 0);

        // Straight-line random code, reset while issuing the instruction at 6.
        for (int i = 0; i < 32; i++) mem[i] = gen_word(0);
        do_reset();
        for (int i = 0; i < 6; i++) do_instr($urandom_range(0, 3), 0);
        chk("pc_before_abort", adp_bus, 6);
        do_instr(0, 1);

        // Fully random program with jumps.
        for (int i = 0; i < 32; i++) mem[i] = gen_word(1);
        do_instr(0, 0);
        for (int i = 0; i < 30; i++) do_instr($urandom_range(0, 3), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
